// File: rtl/fir_seq_ctrl.sv
// Sequencer for a time-multiplexed single-MAC FIR: writes each sample into a circular
// delay line, sweeps taps through ROM/RAM and drives latency-aligned MAC strobes.
module fir_seq_ctrl #(
    parameter int Num_coef = 17,
    parameter int RD_LAT   = 1,
    localparam int AW      = (Num_coef > 1) ? $clog2(Num_coef) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          x_we,
    output logic [AW-1:0] x_wr_addr,
    output logic [AW-1:0] x_rd_addr,
    output logic [AW-1:0] coef_addr,
    output logic          rd_en,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          dout_valid
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(Num_coef - 1);

    state_t            r_state, w_state_nxt;
    logic [AW-1:0]     r_wp, w_wp_nxt;
    logic [AW-1:0]     r_rp, w_rp_nxt;
    logic [AW-1:0]     r_k, w_k_nxt;
    logic [2:0]        r_fcnt, w_fcnt_nxt;
    logic              r_rd_en, w_rd_en_nxt;
    logic              r_din_ready, w_din_ready_nxt;
    logic              r_dout_valid, w_dout_valid_nxt;
    logic [RD_LAT-1:0] r_en_pipe, r_clr_pipe;
    logic              w_xfer;

    // NOTE: the registered ready is masked by rst so the reset cycle itself refuses a
    // sample, while reset loads it high so IDLE is ready on the very next cycle.
    assign din_ready  = r_din_ready & ~rst;
    assign w_xfer     = din_valid & din_ready;
    assign x_we       = w_xfer;
    assign x_wr_addr  = r_wp;
    assign x_rd_addr  = r_rp;
    assign coef_addr  = r_k;
    assign rd_en      = r_rd_en;
    assign mac_en     = r_en_pipe[RD_LAT-1];
    assign mac_clr    = r_clr_pipe[RD_LAT-1];
    assign dout_valid = r_dout_valid;

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_wp_nxt         = r_wp;
        w_rp_nxt         = r_rp;
        w_k_nxt          = r_k;
        w_fcnt_nxt       = r_fcnt;
        w_rd_en_nxt      = 1'b0;
        w_din_ready_nxt  = 1'b0;
        w_dout_valid_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_din_ready_nxt = 1'b1;
                if (w_xfer) begin
                    w_state_nxt     = S_RUN;
                    w_din_ready_nxt = 1'b0;
                    w_rd_en_nxt     = 1'b1;
                    w_k_nxt         = '0;
                    w_rp_nxt        = r_wp;
                    w_wp_nxt        = (r_wp == LAST) ? '0 : r_wp + AW'(1);
                end
            end
            S_RUN: begin
                if (r_k == LAST) begin
                    w_state_nxt = S_FLUSH;
                    w_fcnt_nxt  = '0;
                end else begin
                    w_rd_en_nxt = 1'b1;
                    w_k_nxt     = r_k + AW'(1);
                    w_rp_nxt    = (r_rp == '0) ? LAST : r_rp - AW'(1);
                end
            end
            S_FLUSH: begin
                if (r_fcnt == 3'(RD_LAT - 1)) begin
                    w_state_nxt      = S_DONE;
                    w_dout_valid_nxt = 1'b1;
                end else begin
                    w_fcnt_nxt = r_fcnt + 3'd1;
                end
            end
            S_DONE: begin
                w_state_nxt     = S_IDLE;
                w_din_ready_nxt = 1'b1;
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_din_ready_nxt = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wp         <= '0;
            r_rp         <= '0;
            r_k          <= '0;
            r_fcnt       <= '0;
            r_rd_en      <= 1'b0;
            r_din_ready  <= 1'b1;
            r_dout_valid <= 1'b0;
            r_en_pipe    <= '0;
            r_clr_pipe   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wp         <= w_wp_nxt;
            r_rp         <= w_rp_nxt;
            r_k          <= w_k_nxt;
            r_fcnt       <= w_fcnt_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_din_ready  <= w_din_ready_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            // Delay the read strobe by the memory latency so the MAC sees valid data.
            r_en_pipe[0]  <= r_rd_en;
            r_clr_pipe[0] <= r_rd_en && (r_k == '0);
            for (int i = 1; i < RD_LAT; i++) begin
                r_en_pipe[i]  <= r_en_pipe[i-1];
                r_clr_pipe[i] <= r_clr_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl: one instance with RD_LAT=1, one with RD_LAT=3.
module tb_fir_seq_ctrl;

    localparam int NC = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_1, din_valid_1, din_ready_1, x_we_1, rd_en_1, mac_clr_1, mac_en_1, dout_valid_1;
    logic [4:0] x_wr_addr_1, x_rd_addr_1, coef_addr_1;
    logic       rst_3, din_valid_3, din_ready_3, x_we_3, rd_en_3, mac_clr_3, mac_en_3, dout_valid_3;
    logic [4:0] x_wr_addr_3, x_rd_addr_3, coef_addr_3;

    int total = 0;
    int bad   = 0;

    fir_seq_ctrl #(.Num_coef(NC), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst_1), .din_valid(din_valid_1), .din_ready(din_ready_1),
        .x_we(x_we_1), .x_wr_addr(x_wr_addr_1), .x_rd_addr(x_rd_addr_1),
        .coef_addr(coef_addr_1), .rd_en(rd_en_1), .mac_clr(mac_clr_1),
        .mac_en(mac_en_1), .dout_valid(dout_valid_1)
    );

    fir_seq_ctrl #(.Num_coef(NC), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst_3), .din_valid(din_valid_3), .din_ready(din_ready_3),
        .x_we(x_we_3), .x_wr_addr(x_wr_addr_3), .x_rd_addr(x_rd_addr_3),
        .coef_addr(coef_addr_3), .rd_en(rd_en_3), .mac_clr(mac_clr_3),
        .mac_en(mac_en_3), .dout_valid(dout_valid_3)
    );

    // One full sample frame starting in its transfer cycle (c=0); checks every output
    // each cycle against the expected timeline and leaves the bench at cycle 0 of the next.
    task automatic frame(input int lat, input int base, input bit hold, input int pulse_at,
                         input string tag);
        int len;
        int exp_ra;
        logic s_we, s_rdy, s_rd, s_en, s_clr, s_dv;
        logic [4:0] s_wa, s_ra, s_ca;
        len = NC + lat + 2;
        for (int c = 0; c < len; c++) begin
            if (lat == 1) din_valid_1 = (c == 0) || hold || (c == pulse_at);
            else          din_valid_3 = (c == 0) || hold || (c == pulse_at);
            @(negedge clk);
            if (lat == 1) begin
                s_we = x_we_1; s_rdy = din_ready_1; s_rd = rd_en_1; s_en = mac_en_1;
                s_clr = mac_clr_1; s_dv = dout_valid_1;
                s_wa = x_wr_addr_1; s_ra = x_rd_addr_1; s_ca = coef_addr_1;
            end else begin
                s_we = x_we_3; s_rdy = din_ready_3; s_rd = rd_en_3; s_en = mac_en_3;
                s_clr = mac_clr_3; s_dv = dout_valid_3;
                s_wa = x_wr_addr_3; s_ra = x_rd_addr_3; s_ca = coef_addr_3;
            end
            total++;
            if (s_we !== (c == 0)) begin
                bad++; $display("FAIL %s x_we c=%0d got=%b exp=%b", tag, c, s_we, c == 0);
            end
            total++;
            if (s_rdy !== (c == 0)) begin
                bad++; $display("FAIL %s din_ready c=%0d got=%b exp=%b", tag, c, s_rdy, c == 0);
            end
            total++;
            if (s_rd !== (c >= 1 && c <= NC)) begin
                bad++; $display("FAIL %s rd_en c=%0d got=%b", tag, c, s_rd);
            end
            total++;
            if (s_en !== (c >= 1 + lat && c <= NC + lat)) begin
                bad++; $display("FAIL %s mac_en c=%0d got=%b", tag, c, s_en);
            end
            total++;
            if (s_clr !== (c == 1 + lat)) begin
                bad++; $display("FAIL %s mac_clr c=%0d got=%b", tag, c, s_clr);
            end
            total++;
            if (s_dv !== (c == NC + 1 + lat)) begin
                bad++; $display("FAIL %s dout_valid c=%0d got=%b", tag, c, s_dv);
            end
            if (c == 0) begin
                total++;
                if (s_wa !== 5'(base)) begin
                    bad++; $display("FAIL %s x_wr_addr got=%0d exp=%0d", tag, s_wa, base);
                end
            end
            if (c >= 1 && c <= NC) begin
                exp_ra = (base - (c - 1) + 2 * NC) % NC;
                total++;
                if (s_ca !== 5'(c - 1)) begin
                    bad++; $display("FAIL %s coef_addr c=%0d got=%0d exp=%0d", tag, c, s_ca, c - 1);
                end
                total++;
                if (s_ra !== 5'(exp_ra)) begin
                    bad++; $display("FAIL %s x_rd_addr c=%0d got=%0d exp=%0d", tag, c, s_ra, exp_ra);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_1 = 1'b1; rst_3 = 1'b1;
        din_valid_1 = 1'b1; din_valid_3 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (din_ready_1 !== 1'b0) begin bad++; $display("FAIL reset din_ready got=%b exp=0", din_ready_1); end
        total++;
        if (x_we_1 !== 1'b0) begin bad++; $display("FAIL reset x_we got=%b exp=0", x_we_1); end
        total++;
        if ({rd_en_1, mac_en_1, mac_clr_1, dout_valid_1} !== 4'b0) begin
            bad++; $display("FAIL reset strobes got=%b exp=0000", {rd_en_1, mac_en_1, mac_clr_1, dout_valid_1});
        end
        total++;
        if (x_wr_addr_1 !== 5'd0) begin bad++; $display("FAIL reset x_wr_addr got=%0d exp=0", x_wr_addr_1); end
        total++;
        if (din_ready_3 !== 1'b0) begin bad++; $display("FAIL reset din_ready3 got=%b exp=0", din_ready_3); end
        @(posedge clk); #1;
        rst_1 = 1'b0;
    endtask

    task automatic test_single();
        frame(1, 0, 1'b0, -1, "s1_first");
    endtask

    task automatic test_second();
        frame(1, 1, 1'b0, -1, "s2_second");
    endtask

    task automatic test_ignore_mid_run();
        frame(1, 2, 1'b0, 5, "s4_ignore");
    endtask

    task automatic test_reset_mid_run();
        for (int c = 0; c <= 10; c++) begin
            din_valid_1 = (c == 0);
            rst_1 = (c == 10);
            @(negedge clk);
            if (c == 5) begin
                total++;
                if (rd_en_1 !== 1'b1) begin bad++; $display("FAIL s5 rd_en_run got=%b exp=1", rd_en_1); end
            end
            @(posedge clk); #1;
        end
        rst_1 = 1'b0;
        for (int c = 11; c < 24; c++) begin
            @(negedge clk);
            total++;
            if ({rd_en_1, mac_en_1, dout_valid_1, din_ready_1} !== 4'b0001) begin
                bad++;
                $display("FAIL s5 after_reset c=%0d rd_en,mac_en,dout_valid,din_ready got=%b exp=0001",
                         c, {rd_en_1, mac_en_1, dout_valid_1, din_ready_1});
            end
            @(posedge clk); #1;
        end
        frame(1, 0, 1'b0, -1, "s5_next");
    endtask

    task automatic test_back_to_back_wrap();
        // Post-reset sample above wrote slot 0, so this run starts at slot 1.
        for (int n = 0; n < 18; n++) begin
            frame(1, (n + 1) % NC, n < 17, -1, $sformatf("s3_wrap%0d", n));
        end
    endtask

    task automatic test_lat3();
        rst_3 = 1'b0;
        frame(3, 0, 1'b0, -1, "s6_lat3");
        @(negedge clk);
        total++;
        if (din_ready_3 !== 1'b1) begin bad++; $display("FAIL s6 din_ready_at22 got=%b exp=1", din_ready_3); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_second();
        test_ignore_mid_run();
        test_reset_mid_run();
        test_back_to_back_wrap();
        test_lat3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
